instr_loader: RTL and testbench

- Parametrised successor to the two-press DIP-switch instruction loader.
- Collects BEATS beats of IN_W-bit switch data, one beat per debounced push-button press, into one INSTR_W-bit instruction word.
- Completed words are queued in a DEPTH-entry first-word-fall-through FIFO and handed to the CPU core over a valid/ready handshake.
- Adds over the previous loader: button debouncing, abort of a partial instruction, queueing, and overflow reporting.

---
 rtl/instr_loader_if.sv | 33 +++
 rtl/instr_loader.sv | 195 +++++++++++++++++++
 tb/tb_instr_loader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// -----------------------------------------------------------------------------
// instr_loader_if
//   Valid/ready channel that carries completed instruction words from the
//   loader to the CPU core.
//
//   Signals:
//     instr_out   [INSTR_W] loader -> core, FIFO head word
//     instr_valid           loader -> core, FIFO non-empty
//     instr_ready           core -> loader, head accepted when valid & ready
//
//   Modports:
//     master : the loader (drives word and valid, observes ready)
//     slave  : the core   (observes word and valid, drives ready)
// -----------------------------------------------------------------------------
interface instr_loader_if #(
  parameter int INSTR_W = 16
);
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    output instr_out,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr_out,
    input  instr_valid,
    output instr_ready
  );
endinterface : instr_loader_if

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Assembles BEATS beats of IN_W-bit switch data into one INSTR_W-bit
//   instruction word. Each beat is taken on a debounced push-button press.
//   Completed words go into a DEPTH-entry first-word-fall-through FIFO that
//   feeds the CPU core over a valid/ready handshake.
//
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     data_in       switch data beat, sampled on the press cycle only
//     btn_in        raw asynchronous push button
//     abort_in      discards the partially assembled instruction
//     clr_ovf       clears the sticky overflow flag
//     bus           instr_loader_if master: instr_out / instr_valid / instr_ready
//     beat_idx      next beat to capture
//     busy          a partial instruction is in progress
//     fifo_count    occupied FIFO entries
//     overflow      sticky: a completed word was dropped on a full FIFO
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter  int IN_W        = 8,
  parameter  int BEATS       = 2,
  parameter  int DEPTH       = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int DB_CYCLES   = 4,
  localparam int INSTR_W     = IN_W * BEATS,
  localparam int BI_W        = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int CNT_W       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   data_in,
  input  logic              btn_in,
  input  logic              abort_in,
  input  logic              clr_ovf,
  instr_loader_if.master    bus,
  output logic [BI_W-1:0]   beat_idx,
  output logic              busy,
  output logic [PTR_W:0]    fifo_count,
  output logic              overflow
);

  // ---------------------------------------------------------------------------
  // Button synchroniser, debounce and press detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       db_cnt_q;
  logic                   stable_q;
  logic                   press_q;
  logic                   sync_btn;

  assign sync_btn = sync_q[SYNC_STAGES-1];

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours; blocking here would make the
  // synchroniser collapse into a single stage in simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_in};
      press_q <= 1'b0;
      if (sync_btn == stable_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        // DB_CYCLES consecutive mismatching cycles: accept the new level.
        // Only a rising stable level counts as a press.
        stable_q <= sync_btn;
        db_cnt_q <= '0;
        press_q  <= sync_btn;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Beat sequencing and FIFO control
  // ---------------------------------------------------------------------------
  logic [BI_W-1:0]    beat_idx_q, beat_idx_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, rd_next;
  logic [INSTR_W-1:0] head_q;
  logic [INSTR_W-1:0] push_word;
  logic               ovf_q;
  logic               final_beat, capture, push_req, pop, full, push_ok, drop;

  assign final_beat = (beat_idx_q == BI_W'(BEATS - 1));
  // Abort wins over a coincident press; that press is simply lost.
  assign capture    = press_q && !abort_in;
  assign push_req   = capture && final_beat;
  assign pop        = (count_q != '0) && bus.instr_ready;
  assign full       = (count_q == (PTR_W + 1)'(DEPTH));
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push_ok    = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;
  assign rd_next    = rd_ptr_q + 1'b1;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    beat_idx_d = beat_idx_q;
    count_d    = count_q;
    if (abort_in) begin
      beat_idx_d = '0;
    end else if (press_q) begin
      beat_idx_d = final_beat ? '0 : beat_idx_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Assembly register: holds the lower BEATS-1 beats; the final beat is taken
  // straight from data_in on the push edge.
  // ---------------------------------------------------------------------------
  if (BEATS > 1) begin : g_asm
    logic [(BEATS-1)*IN_W-1:0] asm_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        asm_q <= '0;
      end else if (capture) begin
        for (int b = 0; b < BEATS - 1; b++) begin
          if (beat_idx_q == BI_W'(b)) asm_q[b*IN_W +: IN_W] <= data_in;
        end
      end
    end

    assign push_word = {data_in, asm_q};
  end else begin : g_no_asm
    assign push_word = data_in;
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  logic [INSTR_W-1:0] mem_q [DEPTH];

  // NOTE: the storage array is deliberately not reset; pointers and count
  // alone decide which entries are meaningful, keeping it RAM-mappable.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  // head_q mirrors the FWFT head entry; it keeps its last value once the
  // FIFO drains, and is loaded directly from push_word when the FIFO is
  // (or is about to become) empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      beat_idx_q <= beat_idx_d;
      count_q    <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_next;

      if (pop && (count_q > (PTR_W + 1)'(1))) begin
        head_q <= mem_q[rd_next];
      end else if (push_ok && ((count_q == '0) || pop)) begin
        head_q <= push_word;
      end

      // Set wins over a coincident clear.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.instr_out   = head_q;
  assign bus.instr_valid = (count_q != '0);
  assign beat_idx        = beat_idx_q;
  assign busy            = (beat_idx_q != '0);
  assign fifo_count      = count_q;
  assign overflow        = ovf_q;

endmodule : instr_loader

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//   Directed scenarios followed by randomized button / handshake traffic.
//   A behavioural model (button sample history, beat array, word queue)
//   predicts every output after each clock edge.
// -----------------------------------------------------------------------------
module tb_instr_loader;
  localparam int IN_W        = 8;
  localparam int BEATS       = 2;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int DB_CYCLES   = 4;
  localparam int INSTR_W     = IN_W * BEATS;

  logic            clk;
  logic            rst;
  logic [IN_W-1:0] data_in;
  logic            btn_in;
  logic            abort_in;
  logic            clr_ovf;
  logic [0:0]      beat_idx;
  logic            busy;
  logic [2:0]      fifo_count;
  logic            overflow;

  instr_loader_if #(.INSTR_W(INSTR_W)) bus ();

  instr_loader #(
    .IN_W(IN_W), .BEATS(BEATS), .DEPTH(DEPTH),
    .SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .btn_in    (btn_in),
    .abort_in  (abort_in),
    .clr_ovf   (clr_ovf),
    .bus       (bus),
    .beat_idx  (beat_idx),
    .busy      (busy),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  //   Button: a press is seen when the DB_CYCLES button samples ending
  //   SYNC_STAGES edges ago all differ from the accepted level and the new
  //   level is 1; the beat is captured one edge later.
  // ---------------------------------------------------------------------------
  bit                 m_hist[$];
  bit                 m_stable;
  bit                 m_press;
  int                 m_beat;
  logic [IN_W-1:0]    m_parts[BEATS];
  logic [INSTR_W-1:0] m_q[$];
  bit                 m_ovf;
  logic [INSTR_W-1:0] m_out;

  task automatic model_reset();
    m_hist.delete();
    repeat (SYNC_STAGES + DB_CYCLES) m_hist.push_back(1'b0);
    m_stable = 1'b0;
    m_press  = 1'b0;
    m_beat   = 0;
    m_q.delete();
    m_ovf    = 1'b0;
    m_out    = '0;
  endtask

  task automatic model_edge();
    bit                 do_pop, was_full, change;
    logic [INSTR_W-1:0] w;
    if (rst) begin
      model_reset();
      return;
    end
    do_pop   = (m_q.size() != 0) && bus.instr_ready;
    was_full = (m_q.size() == DEPTH);
    if (clr_ovf) m_ovf = 1'b0;
    if (do_pop) void'(m_q.pop_front());
    if (abort_in) begin
      m_beat = 0;
    end else if (m_press) begin
      m_parts[m_beat] = data_in;
      if (m_beat == BEATS - 1) begin
        w = '0;
        for (int i = 0; i < BEATS; i++) w |= INSTR_W'(m_parts[i]) << (i * IN_W);
        if (was_full && !do_pop) m_ovf = 1'b1;
        else                     m_q.push_back(w);
        m_beat = 0;
      end else begin
        m_beat++;
      end
    end
    if (m_q.size() != 0) m_out = m_q[0];

    m_hist.push_back(btn_in);
    change = 1'b1;
    for (int k = 0; k < DB_CYCLES; k++)
      if (m_hist[m_hist.size() - 1 - SYNC_STAGES - k] == m_stable) change = 1'b0;
    m_press = change && !m_stable;
    if (change) m_stable = !m_stable;
    while (m_hist.size() > 32) void'(m_hist.pop_front());
  endtask

  task automatic check_all();
    check("valid", 64'(bus.instr_valid), 64'(m_q.size() != 0));
    check("count", 64'(fifo_count),      64'(m_q.size()));
    check("beat",  64'(beat_idx),        64'(m_beat));
    check("busy",  64'(busy),            64'(m_beat != 0));
    check("ovf",   64'(overflow),        64'(m_ovf));
    check("out",   64'(bus.instr_out),   64'(m_out));
  endtask

  // One clock: update the model from the pre-edge inputs, then sample the
  // DUT 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic press(input logic [IN_W-1:0] d);
    data_in = d;
    btn_in  = 1'b1;
    repeat (10) tick();
    btn_in  = 1'b0;
    repeat (10) tick();
  endtask

  task automatic pop_one();
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; data_in = '0; btn_in = 1'b0; abort_in = 1'b0; clr_ovf = 1'b0;
    bus.instr_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset, then idle.
    repeat (20) tick();
    check("idle_valid", 64'(bus.instr_valid), 64'h0);
    check("idle_count", 64'(fifo_count),      64'h0);
    check("idle_busy",  64'(busy),            64'h0);
    check("idle_ovf",   64'(overflow),        64'h0);
    check("idle_out",   64'(bus.instr_out),   64'h0);

    // Two-beat word with capture latency check.
    data_in = 8'h3A;
    btn_in  = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 6) check("lat_edge6", 64'(beat_idx), 64'h0);
      if (e == 7) check("lat_edge7", 64'(beat_idx), 64'h1);
    end
    btn_in = 1'b0;
    repeat (10) tick();
    press(8'hC5);
    check("w1_out",   64'(bus.instr_out),   64'hC53A);
    check("w1_valid", 64'(bus.instr_valid), 64'h1);
    check("w1_count", 64'(fifo_count),      64'h1);
    pop_one();
    check("w1_popped", 64'(bus.instr_valid), 64'h0);

    // Glitch and bounce rejection.
    data_in = 8'h5C;
    btn_in  = 1'b1;
    repeat (3) tick();
    btn_in  = 1'b0;
    repeat (10) tick();
    check("glitch_beat", 64'(beat_idx), 64'h0);
    for (int i = 0; i < 10; i++) begin
      btn_in = ~i[0];
      tick();
    end
    check("bounce_beat", 64'(beat_idx), 64'h0);
    btn_in = 1'b1;
    repeat (12) tick();
    check("clean_beat", 64'(beat_idx), 64'h1);
    btn_in = 1'b0;
    repeat (10) tick();
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    check("abort_clr", 64'(beat_idx), 64'h0);

    // Abort between beats, then a full word.
    press(8'h11);
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    press(8'h22);
    press(8'h33);
    check("abort_word",  64'(bus.instr_out), 64'h3322);
    check("abort_count", 64'(fifo_count),    64'h1);
    pop_one();

    // Abort coincident with the capture edge.
    data_in = 8'h44;
    btn_in  = 1'b1;
    repeat (6) tick();
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    check("abort_coinc", 64'(beat_idx), 64'h0);
    repeat (3) tick();
    btn_in = 1'b0;
    repeat (10) tick();
    check("abort_after", 64'(beat_idx), 64'h0);

    // Overflow: five words into a four-deep FIFO.
    for (int k = 1; k <= 5; k++) begin
      press(IN_W'(k));
      press(IN_W'(k));
    end
    check("ovf_count", 64'(fifo_count),    64'h4);
    check("ovf_flag",  64'(overflow),      64'h1);
    check("ovf_head",  64'(bus.instr_out), 64'h0101);
    for (int k = 1; k <= 4; k++) begin
      check("ovf_order", 64'(bus.instr_out), 64'((k << 8) | k));
      pop_one();
    end
    check("ovf_empty", 64'(bus.instr_valid), 64'h0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clr", 64'(overflow), 64'h0);

    // Full FIFO, final beat pushed on the same edge as a pop.
    for (int k = 10; k <= 13; k++) begin
      press(IN_W'(k));
      press(IN_W'(k));
    end
    press(8'h0E);
    data_in = 8'h0E;
    btn_in  = 1'b1;
    repeat (6) tick();
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    check("full_pp_count", 64'(fifo_count), 64'h4);
    check("full_pp_ovf",   64'(overflow),   64'h0);
    repeat (3) tick();
    btn_in = 1'b0;
    repeat (10) tick();
    for (int k = 11; k <= 14; k++) begin
      check("full_pp_order", 64'(bus.instr_out), 64'((k << 8) | k));
      pop_one();
    end

    // Randomized traffic, including short holds and a mid-run reset.
    for (int it = 0; it < 400; it++) begin
      int hold, gap;
      data_in = IN_W'($urandom);
      hold    = $urandom_range(1, 12);
      gap     = $urandom_range(1, 12);
      for (int c = 0; c < hold + gap; c++) begin
        btn_in          = (c < hold);
        bus.instr_ready = ($urandom_range(0, 3) == 0);
        abort_in        = ($urandom_range(0, 39) == 0);
        clr_ovf         = ($urandom_range(0, 19) == 0);
        rst             = (it == 200 && c < 2);
        tick();
      end
    end
    rst = 1'b0; abort_in = 1'b0; clr_ovf = 1'b0; bus.instr_ready = 1'b0; btn_in = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule : tb_instr_loader
